// File: rtl/multi_eq_controller.sv
// BIST-gated sequencer: launches BIST with timeout/retry, then round-robins sel_eq
// across NUM_EQ equation channels with a configurable per-channel dwell.
module multi_eq_controller #(
    parameter int unsigned NUM_EQ       = 2,
    parameter int unsigned SEL_W        = 1,
    parameter int unsigned DWELL        = 1,
    parameter int unsigned CYC_W        = 3,
    parameter int unsigned BIST_TIMEOUT = 255,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             bist_req,
    input  logic             bist_active,
    input  logic             bist_pass,
    output logic             start_bist,
    output logic             normal_active,
    output logic [SEL_W-1:0] sel_eq,
    output logic [CYC_W-1:0] cycle_count,
    output logic [1:0]       retry_count,
    output logic             bist_timeout,
    output logic             fault,
    output logic [2:0]       state_dbg
);

    localparam int unsigned TMR_W   = (BIST_TIMEOUT > 1) ? $clog2(BIST_TIMEOUT) : 1;
    localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_LAUNCH     = 3'd1,
        S_WAIT_BIST  = 3'd2,
        S_WAIT_START = 3'd3,
        S_NORMAL_OP  = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic               seen, seen_nxt;
    logic [1:0]         retry_nxt;
    logic               to_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [DWELL_W-1:0] dwell, dwell_nxt;
    logic [CYC_W-1:0]   cyc_nxt;
    logic               bist_done;
    logic               tmr_expired;

    assign state_dbg = state;

    // State and datapath registers; decoded outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_RESET;
            tmr           <= '0;
            seen          <= 1'b0;
            retry_count   <= 2'd0;
            bist_timeout  <= 1'b0;
            sel_eq        <= '0;
            dwell         <= '0;
            cycle_count   <= '0;
            start_bist    <= 1'b0;
            normal_active <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            tmr           <= tmr_nxt;
            seen          <= seen_nxt;
            retry_count   <= retry_nxt;
            bist_timeout  <= to_nxt;
            sel_eq        <= sel_nxt;
            dwell         <= dwell_nxt;
            cycle_count   <= cyc_nxt;
            start_bist    <= (state_nxt == S_LAUNCH);
            normal_active <= (state_nxt == S_NORMAL_OP);
            fault         <= (state_nxt == S_FAULT);
        end
    end

    // Completion outranks a coincident timeout
    assign bist_done   = seen && !bist_active;
    assign tmr_expired = (tmr == TMR_W'(BIST_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        seen_nxt  = seen;
        retry_nxt = retry_count;
        to_nxt    = bist_timeout;
        sel_nxt   = sel_eq;
        dwell_nxt = dwell;
        cyc_nxt   = cycle_count;

        case (state)
            S_RESET: state_nxt = S_LAUNCH;

            S_LAUNCH: begin
                tmr_nxt   = '0;
                seen_nxt  = 1'b0;
                state_nxt = S_WAIT_BIST;
            end

            S_WAIT_BIST: begin
                tmr_nxt = tmr + TMR_W'(1);
                if (bist_active) begin
                    seen_nxt = 1'b1;
                end
                if (bist_done && bist_pass) begin
                    retry_nxt = 2'd0;
                    state_nxt = S_WAIT_START;
                end else if (bist_done || tmr_expired) begin
                    if (!bist_done) begin
                        to_nxt = 1'b1;
                    end
                    if (32'(retry_count) < MAX_RETRY) begin
                        retry_nxt = (retry_count == 2'd3) ? 2'd3 : retry_count + 2'd1;
                        state_nxt = S_LAUNCH;
                    end else begin
                        state_nxt = S_FAULT;
                    end
                end
            end

            S_WAIT_START: begin
                if (stop) begin
                    state_nxt = S_WAIT_START;
                end else if (bist_req) begin
                    retry_nxt = 2'd0;
                    state_nxt = S_LAUNCH;
                end else if (start) begin
                    state_nxt = S_NORMAL_OP;
                end
            end

            S_NORMAL_OP: begin
                if (stop) begin
                    sel_nxt   = '0;
                    dwell_nxt = '0;
                    state_nxt = S_WAIT_START;
                end else begin
                    cyc_nxt = cycle_count + CYC_W'(1);
                    if (dwell == DWELL_W'(DWELL - 1)) begin
                        dwell_nxt = '0;
                        sel_nxt   = (sel_eq == SEL_W'(NUM_EQ - 1)) ? '0 : sel_eq + SEL_W'(1);
                    end else begin
                        dwell_nxt = dwell + DWELL_W'(1);
                    end
                end
            end

            S_FAULT: state_nxt = S_FAULT;

            default: state_nxt = S_RESET;
        endcase
    end

endmodule
